// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register for the RV32I core.
// Latches the decoded instruction fields and the forwarding selects chosen in ID.
// In EX it resolves the final ALU operands against the MEM and WB bypass data.
// Stall holds the stage and freezes the resolved operands, so forwarded values
// survive their producers retiring. Flush turns the stage into a bubble.
// Optional build macro ID_EX_STALL_CNT_EN adds the Stall_cycles and Flush_count
// saturating performance counters.
module id_ex_operand_stage #(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH         = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          ID_Valid,
  input  logic [REG_DATA_WIDTH-1:0]     ID_PC,
  input  logic [REG_DATA_WIDTH-1:0]     ID_Rs1_data,
  input  logic [REG_DATA_WIDTH-1:0]     ID_Rs2_data,
  input  logic [REG_DATA_WIDTH-1:0]     ID_Imm,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr,
  input  logic                          ID_RegFile_wr_en,
  input  logic [CTRL_WIDTH-1:0]         ID_Ctrl,
  input  logic [1:0]                    ForwardA,
  input  logic [1:0]                    ForwardB,
  input  logic [REG_DATA_WIDTH-1:0]     Fwd_EX_data,
  input  logic [REG_DATA_WIDTH-1:0]     Fwd_MEM_data,
  input  logic                          EX_Stall,
  input  logic                          EX_Flush,
  output logic                          EX_Valid,
  output logic [REG_DATA_WIDTH-1:0]     EX_PC,
  output logic [REG_DATA_WIDTH-1:0]     EX_Imm,
  output logic [REG_DATA_WIDTH-1:0]     EX_Op1,
  output logic [REG_DATA_WIDTH-1:0]     EX_Op2,
  output logic [REGFILE_ADDR_WIDTH-1:0] EX_Rs1_addr,
  output logic [REGFILE_ADDR_WIDTH-1:0] EX_Rs2_addr,
  output logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr,
  output logic                          EX_RegFile_wr_en,
  output logic [CTRL_WIDTH-1:0]         EX_Ctrl
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]                   Stall_cycles,
  output logic [31:0]                   Flush_count
`endif
);

  // Forwarding select encoding; 2'b11 is illegal and falls back to the regfile value.
  localparam logic [1:0] SEL_EX_HAZARD  = 2'b10;
  localparam logic [1:0] SEL_MEM_HAZARD = 2'b01;

  logic [REG_DATA_WIDTH-1:0] op1_q;
  logic [REG_DATA_WIDTH-1:0] op2_q;
  logic [1:0]                sel_a_q;
  logic [1:0]                sel_b_q;
  logic [REG_DATA_WIDTH-1:0] op1_res;
  logic [REG_DATA_WIDTH-1:0] op2_res;

  // Resolve operand 1: pick bypass or raw/frozen value, x0 always reads as zero.
  always_comb begin
    op1_res = op1_q;
    case (sel_a_q)
      SEL_EX_HAZARD:  op1_res = Fwd_EX_data;
      SEL_MEM_HAZARD: op1_res = Fwd_MEM_data;
      default:        op1_res = op1_q;
    endcase
    if (EX_Rs1_addr == '0) op1_res = '0;
  end

  // Resolve operand 2 the same way; this value is also the store data.
  always_comb begin
    op2_res = op2_q;
    case (sel_b_q)
      SEL_EX_HAZARD:  op2_res = Fwd_EX_data;
      SEL_MEM_HAZARD: op2_res = Fwd_MEM_data;
      default:        op2_res = op2_q;
    endcase
    if (EX_Rs2_addr == '0) op2_res = '0;
  end

  assign EX_Op1 = op1_res;
  assign EX_Op2 = op2_res;

  // Stage register: flush beats stall beats capture; stall freezes resolved operands.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      EX_Valid         <= 1'b0;
      EX_PC            <= '0;
      EX_Imm           <= '0;
      op1_q            <= '0;
      op2_q            <= '0;
      sel_a_q          <= 2'b00;
      sel_b_q          <= 2'b00;
      EX_Rs1_addr      <= '0;
      EX_Rs2_addr      <= '0;
      EX_Rd_addr       <= '0;
      EX_RegFile_wr_en <= 1'b0;
      EX_Ctrl          <= '0;
    end else if (EX_Flush) begin
      EX_Valid         <= 1'b0;
      EX_RegFile_wr_en <= 1'b0;
      EX_Ctrl          <= '0;
      sel_a_q          <= 2'b00;
      sel_b_q          <= 2'b00;
    end else if (EX_Stall) begin
      op1_q   <= op1_res;
      op2_q   <= op2_res;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
    end else begin
      EX_Valid         <= ID_Valid;
      EX_PC            <= ID_PC;
      EX_Imm           <= ID_Imm;
      op1_q            <= ID_Rs1_data;
      op2_q            <= ID_Rs2_data;
      sel_a_q          <= ForwardA;
      sel_b_q          <= ForwardB;
      EX_Rs1_addr      <= ID_Rs1_addr;
      EX_Rs2_addr      <= ID_Rs2_addr;
      EX_Rd_addr       <= ID_Rd_addr;
      EX_RegFile_wr_en <= ID_RegFile_wr_en & ID_Valid;
      EX_Ctrl          <= ID_Ctrl;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Saturating counters of stalled edges (flush excluded) and flushed edges.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Stall_cycles <= '0;
      Flush_count  <= '0;
    end else begin
      if (EX_Stall && !EX_Flush && (Stall_cycles != 32'hFFFF_FFFF))
        Stall_cycles <= Stall_cycles + 32'd1;
      if (EX_Flush && (Flush_count != 32'hFFFF_FFFF))
        Flush_count <= Flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: scoreboard bench for the ID/EX operand stage.
// A driver applies one directed vector per cycle and queues the outputs
// expected during that cycle; a monitor compares them at the falling edge.
module tb_id_ex_operand_stage;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] fex;
    logic [31:0] fmem;
    logic        stall;
    logic        flush;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] ctrl;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic        ID_Valid;
  logic [31:0] ID_PC;
  logic [31:0] ID_Rs1_data;
  logic [31:0] ID_Rs2_data;
  logic [31:0] ID_Imm;
  logic [4:0]  ID_Rs1_addr;
  logic [4:0]  ID_Rs2_addr;
  logic [4:0]  ID_Rd_addr;
  logic        ID_RegFile_wr_en;
  logic [15:0] ID_Ctrl;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [31:0] Fwd_EX_data;
  logic [31:0] Fwd_MEM_data;
  logic        EX_Stall;
  logic        EX_Flush;
  logic        EX_Valid;
  logic [31:0] EX_PC;
  logic [31:0] EX_Imm;
  logic [31:0] EX_Op1;
  logic [31:0] EX_Op2;
  logic [4:0]  EX_Rs1_addr;
  logic [4:0]  EX_Rs2_addr;
  logic [4:0]  EX_Rd_addr;
  logic        EX_RegFile_wr_en;
  logic [15:0] EX_Ctrl;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] Stall_cycles;
  logic [31:0] Flush_count;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;
  exp_t expQ[$];

  id_ex_operand_stage dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .ID_Valid         (ID_Valid),
    .ID_PC            (ID_PC),
    .ID_Rs1_data      (ID_Rs1_data),
    .ID_Rs2_data      (ID_Rs2_data),
    .ID_Imm           (ID_Imm),
    .ID_Rs1_addr      (ID_Rs1_addr),
    .ID_Rs2_addr      (ID_Rs2_addr),
    .ID_Rd_addr       (ID_Rd_addr),
    .ID_RegFile_wr_en (ID_RegFile_wr_en),
    .ID_Ctrl          (ID_Ctrl),
    .ForwardA         (ForwardA),
    .ForwardB         (ForwardB),
    .Fwd_EX_data      (Fwd_EX_data),
    .Fwd_MEM_data     (Fwd_MEM_data),
    .EX_Stall         (EX_Stall),
    .EX_Flush         (EX_Flush),
    .EX_Valid         (EX_Valid),
    .EX_PC            (EX_PC),
    .EX_Imm           (EX_Imm),
    .EX_Op1           (EX_Op1),
    .EX_Op2           (EX_Op2),
    .EX_Rs1_addr      (EX_Rs1_addr),
    .EX_Rs2_addr      (EX_Rs2_addr),
    .EX_Rd_addr       (EX_Rd_addr),
    .EX_RegFile_wr_en (EX_RegFile_wr_en),
    .EX_Ctrl          (EX_Ctrl)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .Stall_cycles     (Stall_cycles),
    .Flush_count      (Flush_count)
`endif
  );

  // Free-running 10-time-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic vec_t mkVec(logic valid, logic [31:0] pc, logic [4:0] rs1a, logic [31:0] rs1d,
                                 logic [4:0] rs2a, logic [31:0] rs2d, logic [31:0] imm, logic [4:0] rd,
                                 logic we, logic [15:0] ctrl, logic [1:0] fa, logic [1:0] fb,
                                 logic [31:0] fex, logic [31:0] fmem, logic stall, logic flush);
    vec_t v;
    v.valid = valid; v.pc = pc; v.rs1a = rs1a; v.rs1d = rs1d; v.rs2a = rs2a; v.rs2d = rs2d;
    v.imm = imm; v.rd = rd; v.we = we; v.ctrl = ctrl; v.fa = fa; v.fb = fb;
    v.fex = fex; v.fmem = fmem; v.stall = stall; v.flush = flush;
    return v;
  endfunction

  function automatic exp_t mkExp(logic valid, logic [31:0] pc, logic [31:0] imm, logic [31:0] op1,
                                 logic [31:0] op2, logic [4:0] rs1a, logic [4:0] rs2a, logic [4:0] rd,
                                 logic we, logic [15:0] ctrl);
    exp_t e;
    e.valid = valid; e.pc = pc; e.imm = imm; e.op1 = op1; e.op2 = op2;
    e.rs1a = rs1a; e.rs2a = rs2a; e.rd = rd; e.we = we; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setInputs(input vec_t v);
    ID_Valid         = v.valid;
    ID_PC            = v.pc;
    ID_Rs1_addr      = v.rs1a;
    ID_Rs1_data      = v.rs1d;
    ID_Rs2_addr      = v.rs2a;
    ID_Rs2_data      = v.rs2d;
    ID_Imm           = v.imm;
    ID_Rd_addr       = v.rd;
    ID_RegFile_wr_en = v.we;
    ID_Ctrl          = v.ctrl;
    ForwardA         = v.fa;
    ForwardB         = v.fb;
    Fwd_EX_data      = v.fex;
    Fwd_MEM_data     = v.fmem;
    EX_Stall         = v.stall;
    EX_Flush         = v.flush;
  endtask

  // Drive one cycle just after the rising edge and queue what EX should show in it.
  task automatic applyStimulus(input vec_t v, input exp_t e);
    @(posedge Clk);
    #1;
    setInputs(v);
    expQ.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, {31'd0, EX_Valid}, 32'd0);
    checkOutput({tag, " pc"}, EX_PC, 32'd0);
    checkOutput({tag, " imm"}, EX_Imm, 32'd0);
    checkOutput({tag, " op1"}, EX_Op1, 32'd0);
    checkOutput({tag, " op2"}, EX_Op2, 32'd0);
    checkOutput({tag, " rs1"}, {27'd0, EX_Rs1_addr}, 32'd0);
    checkOutput({tag, " rs2"}, {27'd0, EX_Rs2_addr}, 32'd0);
    checkOutput({tag, " rd"}, {27'd0, EX_Rd_addr}, 32'd0);
    checkOutput({tag, " we"}, {31'd0, EX_RegFile_wr_en}, 32'd0);
    checkOutput({tag, " ctrl"}, {16'd0, EX_Ctrl}, 32'd0);
  endtask

  // Monitor: at each falling edge compare EX outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("valid", {31'd0, EX_Valid}, {31'd0, e.valid});
        checkOutput("pc", EX_PC, e.pc);
        checkOutput("imm", EX_Imm, e.imm);
        checkOutput("op1", EX_Op1, e.op1);
        checkOutput("op2", EX_Op2, e.op2);
        checkOutput("rs1_addr", {27'd0, EX_Rs1_addr}, {27'd0, e.rs1a});
        checkOutput("rs2_addr", {27'd0, EX_Rs2_addr}, {27'd0, e.rs2a});
        checkOutput("rd_addr", {27'd0, EX_Rd_addr}, {27'd0, e.rd});
        checkOutput("wr_en", {31'd0, EX_RegFile_wr_en}, {31'd0, e.we});
        checkOutput("ctrl", {16'd0, EX_Ctrl}, {16'd0, e.ctrl});
        checkOutput("wr_en_gated", {31'd0, EX_RegFile_wr_en & ~EX_Valid}, 32'd0);
      end
    end
  end

  // Directed sequence: forwarding, stall freeze, x0/illegal select, flush, async reset.
  initial begin
    vec_t zeroVec;
    vec_t vD;
    int   waitCycles;
    zeroVec = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    Reset = 1'b1;
    setInputs(zeroVec);
    #3;
    checkAllZero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Cycle 0: EX empty after reset; A enters with EX-hazard on rs1.
    applyStimulus(mkVec(1, 32'h100, 5'd5, 32'h11, 5'd6, 32'h22, 32'h4, 5'd7, 1, 16'h00A1, 2'b10, 2'b00, 0, 0, 0, 0),
                  mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // A in EX: rs1 takes Fwd_EX_data; B enters with MEM-hazard on rs1.
    applyStimulus(mkVec(1, 32'h104, 5'd5, 32'h33, 5'd8, 32'h44, 32'h8, 5'd9, 1, 16'h00B2, 2'b01, 2'b00, 32'hABCD, 32'h77, 0, 0),
                  mkExp(1, 32'h100, 32'h4, 32'hABCD, 32'h22, 5'd5, 5'd6, 5'd7, 1, 16'h00A1));
    // B in EX: rs1 takes Fwd_MEM_data; C enters with EX-hazard on rs2, non-writing.
    applyStimulus(mkVec(1, 32'h108, 5'd3, 32'h55, 5'd4, 32'h66, 32'hC, 5'd10, 0, 16'h00C3, 2'b00, 2'b10, 32'hDEAD, 32'h77, 0, 0),
                  mkExp(1, 32'h104, 32'h8, 32'h77, 32'h44, 5'd5, 5'd8, 5'd9, 1, 16'h00B2));
    // C in EX with Fwd_EX_data=0x1234, then three stall edges while the bypass changes.
    vD = mkVec(1, 32'h10C, 5'd1, 32'hAA, 5'd2, 32'hBB, 32'h10, 5'd11, 1, 16'h00D4, 2'b00, 2'b00, 32'h1234, 0, 1, 0);
    applyStimulus(vD, mkExp(1, 32'h108, 32'hC, 32'h55, 32'h1234, 5'd3, 5'd4, 5'd10, 0, 16'h00C3));
    vD.fex = 32'hFFFF;
    applyStimulus(vD, mkExp(1, 32'h108, 32'hC, 32'h55, 32'h1234, 5'd3, 5'd4, 5'd10, 0, 16'h00C3));
    applyStimulus(vD, mkExp(1, 32'h108, 32'hC, 32'h55, 32'h1234, 5'd3, 5'd4, 5'd10, 0, 16'h00C3));
    vD.stall = 1'b0;
    applyStimulus(vD, mkExp(1, 32'h108, 32'hC, 32'h55, 32'h1234, 5'd3, 5'd4, 5'd10, 0, 16'h00C3));
    // D in EX; E enters with rs1=x0 forwarded and illegal select on rs2.
    applyStimulus(mkVec(1, 32'h110, 5'd0, 32'h99, 5'd12, 32'h9, 32'h14, 5'd13, 1, 16'h00E5, 2'b10, 2'b11, 0, 0, 0, 0),
                  mkExp(1, 32'h10C, 32'h10, 32'hAA, 32'hBB, 5'd1, 5'd2, 5'd11, 1, 16'h00D4));
    // E in EX: op1 forced to 0, op2 keeps raw 0x9.
    applyStimulus(mkVec(1, 32'h114, 5'd14, 32'h1, 5'd15, 32'h2, 32'h18, 5'd16, 1, 16'h00F6, 2'b00, 2'b00, 32'h5, 32'h3, 0, 0),
                  mkExp(1, 32'h110, 32'h14, 32'h0, 32'h9, 5'd0, 5'd12, 5'd13, 1, 16'h00E5));
    // F in EX; stall and flush on the same edge.
    applyStimulus(mkVec(1, 32'h118, 5'd23, 32'h3, 5'd24, 32'h4, 32'h1C, 5'd25, 1, 16'h0A0A, 2'b00, 2'b00, 0, 0, 1, 1),
                  mkExp(1, 32'h114, 32'h18, 32'h1, 32'h2, 5'd14, 5'd15, 5'd16, 1, 16'h00F6));
    // Bubble: control cleared, data held; an invalid writing instruction enters.
    applyStimulus(mkVec(0, 32'h11C, 5'd17, 32'h70, 5'd18, 32'h80, 32'h1C, 5'd19, 1, 16'h1234, 2'b00, 2'b00, 0, 0, 0, 0),
                  mkExp(0, 32'h114, 32'h18, 32'h1, 32'h2, 5'd14, 5'd15, 5'd16, 0, 16'h0000));
    // Invalid instruction in EX: wr_en gated off.
    applyStimulus(mkVec(1, 32'h120, 5'd20, 32'hCAFE, 5'd21, 32'hBEEF, 32'h20, 5'd22, 1, 16'h0F0F, 2'b00, 2'b00, 0, 0, 0, 0),
                  mkExp(0, 32'h11C, 32'h1C, 32'h70, 32'h80, 5'd17, 5'd18, 5'd19, 0, 16'h1234));
    applyStimulus(zeroVec,
                  mkExp(1, 32'h120, 32'h20, 32'hCAFE, 32'hBEEF, 5'd20, 5'd21, 5'd22, 1, 16'h0F0F));

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(negedge Clk);
      waitCycles++;
    end
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    // Asynchronous reset between edges clears EX immediately.
    #2;
    Reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

`ifdef ID_EX_STALL_CNT_EN
    EX_Stall = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    EX_Stall = 1'b0;
    EX_Flush = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    EX_Flush = 1'b0;
    checkOutput("stall_cycles", Stall_cycles, 32'd4);
    checkOutput("flush_count", Flush_count, 32'd2);
    @(negedge Clk);
    EX_Stall = 1'b1;
    force dut.Stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.Stall_cycles;
    @(posedge Clk);
    #1;
    EX_Stall = 1'b0;
    checkOutput("stall_saturate", Stall_cycles, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
